// File: rtl/calc2_port_driver_if.sv
// -----------------------------------------------------------------------------
// calc2_port_driver_if
// Bus bundle between the stimulus source / calc2 DUT port and one
// calc2_port_driver instance.
//   Upstream command : in_valid, in_ready, in_cmd, in_op1, in_op2
//   DUT request      : req_cmd, req_data, req_tag
//   DUT response     : out_resp, out_data, out_tag
//   Upstream result  : rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_cmd
//   Status           : err_unexp, err_timeout, err_tag, busy
// Modports:
//   master : the environment side (drives commands and DUT responses)
//   slave  : the port driver itself
// -----------------------------------------------------------------------------
interface calc2_port_driver_if #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4,
  parameter int TAG_W  = 2
);
  localparam int NTAG = 1 << TAG_W;

  logic              in_valid;
  logic              in_ready;
  logic [CMD_W-1:0]  in_cmd;
  logic [DATA_W-1:0] in_op1;
  logic [DATA_W-1:0] in_op2;

  logic [CMD_W-1:0]  req_cmd;
  logic [DATA_W-1:0] req_data;
  logic [TAG_W-1:0]  req_tag;

  logic [1:0]        out_resp;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;

  logic              rsp_valid;
  logic [1:0]        rsp_resp;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic [CMD_W-1:0]  rsp_cmd;

  logic              err_unexp;
  logic              err_timeout;
  logic [TAG_W-1:0]  err_tag;
  logic [NTAG-1:0]   busy;

  modport master (
    output in_valid, in_cmd, in_op1, in_op2, out_resp, out_data, out_tag,
    input  in_ready, req_cmd, req_data, req_tag,
           rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_cmd,
           err_unexp, err_timeout, err_tag, busy
  );

  modport slave (
    input  in_valid, in_cmd, in_op1, in_op2, out_resp, out_data, out_tag,
    output in_ready, req_cmd, req_data, req_tag,
           rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_cmd,
           err_unexp, err_timeout, err_tag, busy
  );
endinterface

// File: rtl/calc2_port_driver.sv
// -----------------------------------------------------------------------------
// calc2_port_driver
// Per-port request issuer for one calc2_top request/response port.
// Accepts whole commands (cmd, op1, op2) on a valid/ready handshake, allocates
// the lowest free tag, serialises the command onto the two-cycle calc2 request
// protocol (OP1: cmd+op1, OP2: op2), tracks outstanding tags, forwards DUT
// responses upstream with the original cmd, and flags unknown-tag responses
// and tags reclaimed by timeout.
// Ports:
//   c_clk    : clock, all logic on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : calc2_port_driver_if.slave (command, request, response, status)
// -----------------------------------------------------------------------------
module calc2_port_driver #(
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int TAG_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  c_clk,
  input  logic                  reset_n,
  calc2_port_driver_if.slave    bus
);

  localparam int NTAG  = 1 << TAG_W;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OP1, OP2} state_e;

  state_e            state_q, state_d;
  logic [NTAG-1:0]   busy_q, busy_d;
  logic [TMR_W-1:0]  timer_q [NTAG];
  logic [TMR_W-1:0]  timer_d [NTAG];
  logic [CMD_W-1:0]  cmd_mem_q [NTAG];
  logic [NTAG-1:0]   pend_q, pend_d;

  logic [DATA_W-1:0] op2_q;
  logic [TAG_W-1:0]  tag_q;

  logic [CMD_W-1:0]  req_cmd_q, req_cmd_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [CMD_W-1:0]  rsp_cmd_q, rsp_cmd_d;

  logic              err_unexp_q, err_unexp_d;
  logic              err_timeout_q, err_timeout_d;
  logic [TAG_W-1:0]  err_tag_q, err_tag_d;

  logic              accept;
  logic [TAG_W-1:0]  alloc_tag;
  logic              rsp_hit, unexp_hit;
  logic              to_hit;
  logic [TAG_W-1:0]  to_tag;
  logic              pend_any;
  logic [TAG_W-1:0]  pend_sel;

  // in_ready looks only at registered busy, so a tag freed this cycle is not
  // handed out until the next one.
  assign bus.in_ready = reset_n & (state_q != OP1) & ~(&busy_q);
  assign accept       = bus.in_valid & bus.in_ready;

  assign rsp_hit   = (bus.out_resp != 2'd0) &  busy_q[bus.out_tag];
  assign unexp_hit = (bus.out_resp != 2'd0) & ~busy_q[bus.out_tag];

  // Lowest-index free tag (the downward loop leaves the smallest index last).
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    alloc_tag = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = TAG_W'(i);
    end
  end

  // Timeout detection; a response on the same tag this cycle takes priority.
  always_comb begin
    to_hit = 1'b0;
    to_tag = '0;
    for (int i = 0; i < NTAG; i++) begin
      if (busy_q[i] && timer_q[i] == TMR_LAST &&
          !(rsp_hit && bus.out_tag == TAG_W'(i))) begin
        to_hit = 1'b1;
        to_tag = TAG_W'(i);
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (rsp_hit) busy_d[bus.out_tag] = 1'b0;
    if (to_hit)  busy_d[to_tag]      = 1'b0;
    if (accept)  busy_d[alloc_tag]   = 1'b1;
    // A timer runs only while its tag stays busy; a fresh allocation or a
    // reclaim returns it to zero.
    for (int i = 0; i < NTAG; i++) begin
      timer_d[i] = (busy_q[i] && busy_d[i]) ? timer_q[i] + 1'b1 : '0;
    end
  end

  // Timeouts that collide with an unexpected-response report wait in pend_q
  // and are reported on the next cycle without an unexpected response.
  always_comb begin
    pend_any = |pend_q;
    pend_sel = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (pend_q[i]) pend_sel = TAG_W'(i);
    end
  end

  always_comb begin
    err_unexp_d   = unexp_hit;
    err_timeout_d = 1'b0;
    err_tag_d     = '0;
    pend_d        = pend_q;
    if (unexp_hit) begin
      err_tag_d = bus.out_tag;
      if (to_hit) pend_d[to_tag] = 1'b1;
    end else if (pend_any) begin
      err_timeout_d    = 1'b1;
      err_tag_d        = pend_sel;
      pend_d[pend_sel] = 1'b0;
      if (to_hit) pend_d[to_tag] = 1'b1;
    end else if (to_hit) begin
      err_timeout_d = 1'b1;
      err_tag_d     = to_tag;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_hit;
    rsp_resp_d  = rsp_hit ? bus.out_resp : 2'd0;
    rsp_data_d  = rsp_hit ? bus.out_data : '0;
    rsp_tag_d   = rsp_hit ? bus.out_tag  : '0;
    rsp_cmd_d   = rsp_hit ? cmd_mem_q[bus.out_tag] : '0;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? OP1 : IDLE;
      OP1:     state_d = OP2;
      OP2:     state_d = accept ? OP1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. The request bus is registered, so its value is derived from
  // the state being entered; OP1 is entered only on accept.
  always_comb begin
    req_cmd_d  = '0;
    req_data_d = '0;
    req_tag_d  = '0;
    unique case (state_d)
      OP1: begin
        req_cmd_d  = bus.in_cmd;
        req_data_d = bus.in_op1;
        req_tag_d  = alloc_tag;
      end
      OP2: begin
        req_data_d = op2_q;
        req_tag_d  = tag_q;
      end
      default: ;
    endcase
  end

  // FSM: state register plus all other control/status state.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q       <= IDLE;
      busy_q        <= '0;
      pend_q        <= '0;
      for (int i = 0; i < NTAG; i++) timer_q[i] <= '0;
      op2_q         <= '0;
      tag_q         <= '0;
      req_cmd_q     <= '0;
      req_data_q    <= '0;
      req_tag_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_resp_q    <= '0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_cmd_q     <= '0;
      err_unexp_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_tag_q     <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      pend_q        <= pend_d;
      for (int i = 0; i < NTAG; i++) timer_q[i] <= timer_d[i];
      if (accept) begin
        op2_q <= bus.in_op2;
        tag_q <= alloc_tag;
      end
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      req_tag_q     <= req_tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_data_q    <= rsp_data_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_cmd_q     <= rsp_cmd_d;
      err_unexp_q   <= err_unexp_d;
      err_timeout_q <= err_timeout_d;
      err_tag_q     <= err_tag_d;
    end
  end

  // NOTE: cmd_mem has no reset; an entry is only read while its busy bit is
  // set, and that bit is only set in the same cycle the entry is written.
  always_ff @(posedge c_clk) begin
    if (accept) cmd_mem_q[alloc_tag] <= bus.in_cmd;
  end

  assign bus.req_cmd     = req_cmd_q;
  assign bus.req_data    = req_data_q;
  assign bus.req_tag     = req_tag_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_resp    = rsp_resp_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign bus.rsp_cmd     = rsp_cmd_q;
  assign bus.err_unexp   = err_unexp_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_tag     = err_tag_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_calc2_port_driver.sv
// -----------------------------------------------------------------------------
// tb_calc2_port_driver
// Self-checking bench for calc2_port_driver. Instance dut (TIMEOUT=64) covers
// issue, tag allocation, response forwarding, unexpected responses and reset;
// instance dut2 (TIMEOUT=8) covers timeout timing and its interactions.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_calc2_port_driver;

  logic c_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 c_clk = ~c_clk;

  calc2_port_driver_if #(.DATA_W(32), .CMD_W(4), .TAG_W(2)) bus ();
  calc2_port_driver_if #(.DATA_W(32), .CMD_W(4), .TAG_W(2)) bus2 ();

  calc2_port_driver #(.DATA_W(32), .CMD_W(4), .TAG_W(2), .TIMEOUT(64)) dut (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  calc2_port_driver #(.DATA_W(32), .CMD_W(4), .TAG_W(2), .TIMEOUT(8)) dut2 (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    logic [3:0]  cmd;
  } rsp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  exp_tag;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } rvec_t;

  rsp_t       sb[$];
  logic [3:0] tb_busy = '0;
  logic [3:0] tb_cmd [4];
  int         checks = 0;
  int         failures = 0;
  int         n_unexp = 0;
  int         n_to = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer and pulse counters for the main instance.
  always @(negedge c_clk) begin
    if (reset_n) begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got tag %0h, want no response (t=%0t)", bus.rsp_tag, $time);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          check("rsp_resp", bus.rsp_resp, e.resp);
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_tag",  bus.rsp_tag,  e.tag);
          check("rsp_cmd",  bus.rsp_cmd,  e.cmd);
        end
      end
      if (bus.err_unexp)   n_unexp++;
      if (bus.err_timeout) n_to++;
    end
  end

  // Issue one command on the main instance and check both request cycles.
  // Returns on the falling edge where the OP2 drive is visible.
  task automatic send_cmd(input logic [3:0] cmd, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [1:0] exp_tag);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge c_clk);
      n++;
    end
    check("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_cmd   = cmd;
    bus.in_op1   = op1;
    bus.in_op2   = op2;
    @(negedge c_clk);
    bus.in_valid = 1'b0;
    tb_busy[exp_tag] = 1'b1;
    tb_cmd[exp_tag]  = cmd;
    check("op1_req_cmd",  bus.req_cmd,  cmd);
    check("op1_req_data", bus.req_data, op1);
    check("op1_req_tag",  bus.req_tag,  exp_tag);
    check("op1_busy",     bus.busy,     tb_busy);
    @(negedge c_clk);
    check("op2_req_cmd",  bus.req_cmd,  4'h0);
    check("op2_req_data", bus.req_data, op2);
    check("op2_req_tag",  bus.req_tag,  exp_tag);
  endtask

  // Present one DUT response for a cycle; queue the expectation if the tag
  // is outstanding in the bench's own model.
  task automatic respond(input logic [1:0] resp, input logic [31:0] data, input logic [1:0] tag);
    if (tb_busy[tag]) begin
      rsp_t e;
      e.resp = resp; e.data = data; e.tag = tag; e.cmd = tb_cmd[tag];
      sb.push_back(e);
      tb_busy[tag] = 1'b0;
    end
    bus.out_resp = resp;
    bus.out_data = data;
    bus.out_tag  = tag;
    @(negedge c_clk);
    bus.out_resp = 2'd0;
    bus.out_data = '0;
    bus.out_tag  = '0;
  endtask

  // Timeout scenarios on dut2 (TIMEOUT=8). mode 0: no response; mode 1:
  // response on cycle 7; mode 2: unexpected response on another tag on cycle 7.
  task automatic to_run(input int mode);
    @(negedge c_clk);
    check("to_in_ready", bus2.in_ready, 1'b1);
    bus2.in_valid = 1'b1;
    bus2.in_cmd   = 4'h3;
    bus2.in_op1   = 32'h0000_0A0A;
    bus2.in_op2   = 32'h0000_0B0B;
    @(negedge c_clk);
    bus2.in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge c_clk);
      check("to_early_timeout", bus2.err_timeout, 1'b0);
    end
    if (mode == 1) begin
      bus2.out_resp = 2'd1; bus2.out_data = 32'd99; bus2.out_tag = 2'd0;
    end else if (mode == 2) begin
      bus2.out_resp = 2'd2; bus2.out_data = 32'd0;  bus2.out_tag = 2'd2;
    end
    @(negedge c_clk);
    bus2.out_resp = 2'd0; bus2.out_data = '0; bus2.out_tag = '0;
    check("to_busy_cleared", bus2.busy, 4'h0);
    if (mode == 0) begin
      check("to_err_timeout", bus2.err_timeout, 1'b1);
      check("to_err_tag",     bus2.err_tag,     2'd0);
      check("to_rsp_valid",   bus2.rsp_valid,   1'b0);
    end else if (mode == 1) begin
      check("race_err_timeout", bus2.err_timeout, 1'b0);
      check("race_rsp_valid",   bus2.rsp_valid,   1'b1);
      check("race_rsp_data",    bus2.rsp_data,    32'd99);
      check("race_rsp_cmd",     bus2.rsp_cmd,     4'h3);
      check("race_rsp_resp",    bus2.rsp_resp,    2'd1);
    end else begin
      check("coll_err_unexp",   bus2.err_unexp,   1'b1);
      check("coll_err_tag",     bus2.err_tag,     2'd2);
      check("coll_err_timeout", bus2.err_timeout, 1'b0);
      @(negedge c_clk);
      check("defer_err_timeout", bus2.err_timeout, 1'b1);
      check("defer_err_tag",     bus2.err_tag,     2'd0);
      check("defer_err_unexp",   bus2.err_unexp,   1'b0);
    end
    @(negedge c_clk);
    check("to_single_pulse", bus2.err_timeout, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[4];
    rvec_t rvecs[4];
    vecs[0] = '{cmd: 4'h2, op1: 32'h0000_0011, op2: 32'h0000_0022, exp_tag: 2'd0};
    vecs[1] = '{cmd: 4'h5, op1: 32'hDEAD_0001, op2: 32'hBEEF_0001, exp_tag: 2'd1};
    vecs[2] = '{cmd: 4'h9, op1: 32'h1234_5678, op2: 32'h8765_4321, exp_tag: 2'd2};
    vecs[3] = '{cmd: 4'hF, op1: 32'hFFFF_FFFF, op2: 32'h0000_0001, exp_tag: 2'd3};
    rvecs[0] = '{resp: 2'd3, data: 32'h0000_3333, tag: 2'd0};
    rvecs[1] = '{resp: 2'd1, data: 32'h0000_1111, tag: 2'd1};
    rvecs[2] = '{resp: 2'd1, data: 32'hCAFE_F00D, tag: 2'd3};
    rvecs[3] = '{resp: 2'd2, data: 32'h0000_7777, tag: 2'd2};

    bus.in_valid = 1'b0; bus.in_cmd = '0; bus.in_op1 = '0; bus.in_op2 = '0;
    bus.out_resp = '0;   bus.out_data = '0; bus.out_tag = '0;
    bus2.in_valid = 1'b0; bus2.in_cmd = '0; bus2.in_op1 = '0; bus2.in_op2 = '0;
    bus2.out_resp = '0;   bus2.out_data = '0; bus2.out_tag = '0;

    // Reset state.
    #1;
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_req_cmd",   bus.req_cmd,   4'h0);
    check("rst_busy",      bus.busy,      4'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge c_clk);
    check("rst_in_ready_held", bus.in_ready, 1'b0);
    @(negedge c_clk);
    reset_n = 1'b1;
    @(negedge c_clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // Single command and its response.
    send_cmd(4'h1, 32'd5, 32'd7, 2'd0);
    respond(2'd1, 32'd12, 2'd0);
    check("t2_rsp_valid", bus.rsp_valid, 1'b1);
    check("t2_busy",      bus.busy,      4'h0);
    check("t2_idle_cmd",  bus.req_cmd,   4'h0);
    check("t2_idle_data", bus.req_data,  32'h0);

    // Back-to-back issue fills all tags in order.
    for (int i = 0; i < 4; i++) begin
      send_cmd(vecs[i].cmd, vecs[i].op1, vecs[i].op2, vecs[i].exp_tag);
    end
    check("full_in_ready", bus.in_ready, 1'b0);
    check("full_busy",     bus.busy,     4'hF);
    respond(2'd2, 32'h0000_ABCD, 2'd2);
    check("freed_busy",     bus.busy,     4'hB);
    check("freed_in_ready", bus.in_ready, 1'b1);
    send_cmd(4'h7, 32'h0000_0101, 32'h0000_0202, 2'd2);
    for (int i = 0; i < 4; i++) begin
      respond(rvecs[i].resp, rvecs[i].data, rvecs[i].tag);
    end
    @(negedge c_clk);
    check("drain_busy", bus.busy, 4'h0);

    // Response on a tag that is not outstanding.
    respond(2'd2, 32'h0000_DEAD, 2'd3);
    check("unexp_err",       bus.err_unexp, 1'b1);
    check("unexp_err_tag",   bus.err_tag,   2'd3);
    check("unexp_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge c_clk);
    check("unexp_single", bus.err_unexp, 1'b0);

    // Timeout scenarios on the short-timeout instance.
    to_run(0);
    to_run(1);
    to_run(2);

    // Reset while in OP2 drops the command.
    send_cmd(4'h6, 32'h0000_1234, 32'h0000_5678, 2'd0);
    #2;
    reset_n = 1'b0;
    tb_busy = '0;
    #1;
    check("mid_rst_req_cmd",  bus.req_cmd,  4'h0);
    check("mid_rst_req_data", bus.req_data, 32'h0);
    check("mid_rst_req_tag",  bus.req_tag,  2'd0);
    check("mid_rst_busy",     bus.busy,     4'h0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    @(negedge c_clk);
    @(negedge c_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge c_clk);
    check("post_rst_busy", bus.busy, 4'h0);

    // Pulse totals over the whole run on the main instance.
    check("total_err_unexp",   n_unexp,   1);
    check("total_err_timeout", n_to,      0);
    check("sb_drained",        sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
